dbu_mem_viewer: RTL and testbench

Debug-unit front end that lets an operator browse the CPU's 256×32 data memory through its second, read-only port. It synchronizes and debounces the step buttons, keeps the browse address and drives `m_rf_addr`. It registers the returned `m_data` together with the address it belongs to, for the display/LED driver downstream. The block also offers an auto-scan mode that steps the address periodically.

---
 rtl/dbu_pkg.sv | 19 +
 rtl/btn_debounce.sv | 55 +++++
 rtl/dbu_mem_viewer.sv | 137 +++++++++++++
 tb/tb_dbu_mem_viewer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbu_pkg.sv
// Shared types for the debug-unit memory viewer.
// Address width default, viewer FSM states and step directions.
package dbu_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W         = 32;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } viewer_state_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_dir_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability
// counter, and a one-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          lvl_q, lvl_d;
  logic          lvl_dly_q, lvl_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    lvl_d     = lvl_q;
    lvl_dly_d = lvl_q;
    cnt_d     = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level = lvl_q;
  assign rise  = lvl_q & ~lvl_dly_q;

endmodule

// File: rtl/dbu_mem_viewer.sv
// Debug-unit data-memory browser: button/scan address stepping
// and a registered address/data pair for the display driver.
module dbu_mem_viewer
  import dbu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_PERIOD     = 50_000_000,
  parameter int ADDR_W          = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic              scan_en,
  input  logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_rf_addr,
  output logic [ADDR_W-1:0] view_addr,
  output logic [DATA_W-1:0] view_data,
  output logic              view_valid
);

  localparam int TW = $clog2(SCAN_PERIOD);

  logic inc_lvl, inc_rise;
  logic dec_lvl, dec_rise;
  logic unused_lvl;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_inc (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_inc),
    .level  (inc_lvl),
    .rise   (inc_rise)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_dec (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_dec),
    .level  (dec_lvl),
    .rise   (dec_rise)
  );

  assign unused_lvl = inc_lvl ^ dec_lvl;

  logic              scan_s1_q, scan_s1_d;
  logic              scan_s2_q, scan_s2_d;
  viewer_state_t     state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic [DATA_W-1:0] vdata_q, vdata_d;
  logic              valid_q, valid_d;
  step_dir_t         step;

  always_comb begin
    step = STEP_NONE;
    unique case (1'b1)
      inc_rise & ~dec_rise: step = STEP_UP;
      dec_rise & ~inc_rise: step = STEP_DOWN;
      default:              step = STEP_NONE;
    endcase
  end

  always_comb begin
    scan_s1_d = scan_en;
    scan_s2_d = scan_s1_q;
    state_d   = state_q;
    timer_d   = timer_q;
    addr_d    = addr_q;
    vaddr_d   = addr_q;
    vdata_d   = m_data;
    valid_d   = 1'b1;
    unique case (state_q)
      MANUAL: begin
        if (scan_s2_q) begin
          state_d = SCAN;
          timer_d = '0;
        end else begin
          unique case (step)
            STEP_UP:   addr_d = addr_q + ADDR_W'(1);
            STEP_DOWN: addr_d = addr_q - ADDR_W'(1);
            default:   addr_d = addr_q;
          endcase
        end
      end
      SCAN: begin
        // leaving scan wins over a coincident terminal count
        if (!scan_s2_q) begin
          state_d = MANUAL;
          timer_d = '0;
        end else if (timer_q == TW'(SCAN_PERIOD - 1)) begin
          timer_d = '0;
          addr_d  = addr_q + ADDR_W'(1);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = MANUAL;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_s1_q <= 1'b0;
      scan_s2_q <= 1'b0;
      state_q   <= MANUAL;
      timer_q   <= '0;
      addr_q    <= '0;
      vaddr_q   <= '0;
      vdata_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      scan_s1_q <= scan_s1_d;
      scan_s2_q <= scan_s2_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      addr_q    <= addr_d;
      vaddr_q   <= vaddr_d;
      vdata_q   <= vdata_d;
      valid_q   <= valid_d;
    end
  end

  assign m_rf_addr  = addr_q;
  assign view_addr  = vaddr_q;
  assign view_data  = vdata_q;
  assign view_valid = valid_q;

endmodule

// File: tb/tb_dbu_mem_viewer.sv
// Scoreboard bench for dbu_mem_viewer: stimulus queues expected
// address steps, a negedge monitor pops and checks them.
module tb_dbu_mem_viewer;

  localparam int DEB = 4;
  localparam int SP  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        btn_inc = 1'b0;
  logic        btn_dec = 1'b0;
  logic        scan_en = 1'b0;
  logic [31:0] m_data;
  logic [7:0]  m_rf_addr;
  logic [7:0]  view_addr;
  logic [31:0] view_data;
  logic        view_valid;

  logic [31:0] mem [256];

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int         edge_n;
    logic [7:0] addr;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign m_data = mem[m_rf_addr];

  dbu_mem_viewer #(
    .DEBOUNCE_CYCLES(DEB),
    .SCAN_PERIOD    (SP),
    .ADDR_W         (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .scan_en   (scan_en),
    .m_data    (m_data),
    .m_rf_addr (m_rf_addr),
    .view_addr (view_addr),
    .view_data (view_data),
    .view_valid(view_valid)
  );

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_m_rf_addr"}, 32'(m_rf_addr), 32'h0);
    chk({tag, "_view_addr"}, 32'(view_addr), 32'h0);
    chk({tag, "_view_data"}, view_data, 32'h0);
    chk({tag, "_view_valid"}, 32'(view_valid), 32'h0);
  endtask

  task automatic expect_step(int at, logic [7:0] a);
    exp_t e;
    e.edge_n = at;
    e.addr   = a;
    q.push_back(e);
  endtask

  task automatic do_reset();
    chk("queue_drained", 32'(q.size()), 32'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("rst");
    wait_cyc(2);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid_after_edge", 32'(view_valid), 32'h1);
    @(negedge clk);
  endtask

  task automatic press(logic inc, logic dec, int hold, int rel);
    btn_inc = inc;
    btn_dec = dec;
    wait_cyc(hold);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    wait_cyc(rel);
  endtask

  // monitor: any address change must match the head of the queue
  initial begin
    logic [7:0] prev;
    logic       pend;
    logic [7:0] pend_a;
    exp_t       e;
    prev = 8'h0;
    pend = 1'b0;
    pend_a = 8'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 8'h0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("view_addr_follow", 32'(view_addr), 32'(pend_a));
          chk("view_data_follow", view_data,
              32'hA500_0000 | 32'(pend_a));
          pend = 1'b0;
        end
        if (view_valid)
          chk("view_coherent", view_data,
              32'hA500_0000 | 32'(view_addr));
        if (m_rf_addr !== prev) begin
          if (q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_step: got %h expected %h",
                     m_rf_addr, prev);
          end else begin
            e = q.pop_front();
            chk("step_addr", 32'(m_rf_addr), 32'(e.addr));
            chk("step_edge", cyc, e.edge_n);
          end
          prev = m_rf_addr;
          pend = 1'b1;
          pend_a = m_rf_addr;
        end
      end
    end
  end

  initial begin
    int b;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;

    // reset, then first edge after release
    #1 rst_n = 1'b0;
    #2;
    chk_zero("por");
    wait_cyc(2);
    rst_n = 1'b1;
    #1;
    chk("por_valid_pre_edge", 32'(view_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("por_valid", 32'(view_valid), 32'h1);
    chk("por_view_addr", 32'(view_addr), 32'h0);
    chk("por_view_data", view_data, 32'hA500_0000);
    @(negedge clk);

    // held inc: one step at edge 7, no repeat
    btn_inc = 1'b1;
    expect_step(cyc + 7, 8'd1);
    wait_cyc(20);
    btn_inc = 1'b0;
    wait_cyc(10);
    chk("inc_hold_addr", 32'(m_rf_addr), 32'd1);

    // dec glitch ignored, held dec wraps 0 -> 255
    do_reset();
    press(1'b0, 1'b1, 2, 6);
    btn_dec = 1'b1;
    expect_step(cyc + 7, 8'd255);
    wait_cyc(8);
    btn_dec = 1'b0;
    wait_cyc(10);
    chk("dec_wrap_data", view_data, 32'hA500_00FF);

    // walk up to 10 (wrapping through 0), then both together
    for (int i = 0; i < 11; i++) begin
      expect_step(cyc + 7, 8'(i));
      press(1'b1, 1'b0, 8, 8);
    end
    press(1'b1, 1'b1, 10, 10);
    chk("both_hold_addr", 32'(m_rf_addr), 32'd10);

    // scan from 254 with a button press inside the scan
    do_reset();
    expect_step(cyc + 7, 8'd255);
    press(1'b0, 1'b1, 8, 8);
    expect_step(cyc + 7, 8'd254);
    press(1'b0, 1'b1, 8, 8);
    scan_en = 1'b1;
    b = cyc;
    expect_step(b + 11, 8'd255);
    expect_step(b + 19, 8'd0);
    expect_step(b + 27, 8'd1);
    expect_step(b + 35, 8'd2);
    wait_cyc(14);
    press(1'b1, 1'b0, 8, 18);
    scan_en = 1'b0;
    wait_cyc(12);
    chk("scan_exit_addr", 32'(m_rf_addr), 32'd2);

    // reset mid-scan and mid-debounce
    scan_en = 1'b1;
    b = cyc;
    expect_step(b + 11, 8'd3);
    wait_cyc(14);
    btn_inc = 1'b1;
    wait_cyc(3);
    chk("mid_queue_drained", 32'(q.size()), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    btn_inc = 1'b0;
    scan_en = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(20);
    chk("post_rst_addr", 32'(m_rf_addr), 32'd0);
    chk("post_rst_valid", 32'(view_valid), 32'd1);

    chk("final_queue_empty", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
